// File: rtl/ip_stride_pf_queue_if.sv
// rtl/ip_stride_pf_queue_if.sv - demand-train and prefetch-issue signal bundle for ip_stride_pf_queue
interface ip_stride_pf_queue_if #(
    parameter int ADDR_W = 64,
    parameter int DEG_W  = 4
);
    logic              req_valid_i;
    logic [ADDR_W-1:0] addr_i;
    logic [ADDR_W-1:0] ip_i;
    logic [DEG_W-1:0]  degree_i;
    logic              flush_i;
    logic              pf_valid_o;
    logic [ADDR_W-1:0] pf_addr_o;
    logic              pf_ready_i;
    logic [31:0]       pf_issued_o;

    modport master (
        output req_valid_i, addr_i, ip_i, degree_i, flush_i, pf_ready_i,
        input  pf_valid_o, pf_addr_o, pf_issued_o
    );

    modport slave (
        input  req_valid_i, addr_i, ip_i, degree_i, flush_i, pf_ready_i,
        output pf_valid_o, pf_addr_o, pf_issued_o
    );
endinterface

// File: rtl/ip_stride_pf_queue.sv
// rtl/ip_stride_pf_queue.sv - per-IP stride prefetcher with LRU tracker table, generator FSM and output FIFO
module ip_stride_pf_queue #(
    parameter int NUM_TRACKERS = 64,
    parameter int ADDR_W       = 64,
    parameter int LOG2_BLOCK   = 6,
    parameter int LOG2_PAGE    = 12,
    parameter int MAX_DEGREE   = 8,
    parameter int CONF_BITS    = 2,
    parameter int CONF_THRESH  = 2,
    parameter int QUEUE_DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    ip_stride_pf_queue_if.slave    bus
);
    localparam int CLA_W = ADDR_W - LOG2_BLOCK;
    localparam int LRU_W = $clog2(NUM_TRACKERS);
    localparam int DEG_W = $clog2(MAX_DEGREE + 1);
    localparam int PG_SH = LOG2_PAGE - LOG2_BLOCK;
    localparam int QA_W  = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = QA_W + 1;

    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;
    localparam logic [CONF_BITS-1:0] CONF_TH  = CONF_BITS'(CONF_THRESH);
    localparam logic [DEG_W-1:0]     DEG_MAX  = DEG_W'(MAX_DEGREE);
    localparam logic [CNT_W-1:0]     CNT_FULL = CNT_W'(QUEUE_DEPTH);
    localparam logic [LRU_W-1:0]     LRU_OLD  = LRU_W'(NUM_TRACKERS - 1);

    typedef logic [CLA_W-1:0] cla_t;
    typedef enum logic {S_IDLE, S_GEN} state_e;

    logic                 valid_q    [NUM_TRACKERS];
    logic [ADDR_W-1:0]    ip_q       [NUM_TRACKERS];
    cla_t                 last_cla_q [NUM_TRACKERS];
    cla_t                 stride_q   [NUM_TRACKERS];
    logic [CONF_BITS-1:0] conf_q     [NUM_TRACKERS];
    logic [LRU_W-1:0]     lru_q      [NUM_TRACKERS];

    logic             hit;
    logic [LRU_W-1:0] hit_idx, victim_idx, upd_idx, old_lru;
    cla_t             cla, d;
    logic             d_zero, d_match, upd, trig;
    logic [CONF_BITS-1:0] cur_conf, conf_inc, conf_dec;
    logic [DEG_W-1:0] deg_clamp;
    logic             unused_addr_bits;

    assign cla              = bus.addr_i[ADDR_W-1:LOG2_BLOCK];
    assign unused_addr_bits = ^bus.addr_i[LOG2_BLOCK-1:0];

    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        victim_idx = '0;
        for (int i = 0; i < NUM_TRACKERS; i++) begin
            if (valid_q[i] && ip_q[i] == bus.ip_i) begin
                hit     = 1'b1;
                hit_idx = LRU_W'(i);
            end
            if (lru_q[i] == LRU_OLD) victim_idx = LRU_W'(i);
        end
    end

    assign d         = cla - last_cla_q[hit_idx];
    assign d_zero    = (d == '0);
    assign d_match   = (d == stride_q[hit_idx]);
    assign cur_conf  = conf_q[hit_idx];
    assign conf_inc  = (cur_conf == CONF_MAX) ? CONF_MAX : cur_conf + 1'b1;
    assign conf_dec  = (cur_conf == '0) ? '0 : cur_conf - 1'b1;
    assign upd       = bus.req_valid_i && (!hit || !d_zero);
    assign upd_idx   = hit ? hit_idx : victim_idx;
    assign old_lru   = lru_q[upd_idx];
    assign deg_clamp = (bus.degree_i > DEG_MAX) ? DEG_MAX : bus.degree_i;
    assign trig      = bus.req_valid_i && hit && !d_zero && d_match &&
                       (conf_inc >= CONF_TH) && (bus.degree_i != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TRACKERS; i++) begin
                valid_q[i]    <= 1'b0;
                ip_q[i]       <= '0;
                last_cla_q[i] <= '0;
                stride_q[i]   <= '0;
                conf_q[i]     <= '0;
                lru_q[i]      <= LRU_W'(i);
            end
        end else if (upd) begin
            for (int i = 0; i < NUM_TRACKERS; i++) begin
                if (LRU_W'(i) == upd_idx)   lru_q[i] <= '0;
                else if (lru_q[i] < old_lru) lru_q[i] <= lru_q[i] + 1'b1;
            end
            last_cla_q[upd_idx] <= cla;
            if (!hit) begin
                valid_q[upd_idx]  <= 1'b1;
                ip_q[upd_idx]     <= bus.ip_i;
                stride_q[upd_idx] <= '0;
                conf_q[upd_idx]   <= '0;
            end else if (d_match) begin
                conf_q[upd_idx] <= conf_inc;
            end else begin
                conf_q[upd_idx] <= conf_dec;
                if (cur_conf == '0) stride_q[upd_idx] <= d;
            end
        end
    end

    // Generator: walks base + k*stride one candidate per cycle, stalls on a full queue.
    state_e           state_q, state_d;
    cla_t             base_q, base_d, s_q, s_d, cand;
    logic [DEG_W-1:0] deg_q, deg_d, k_q, k_d;
    logic             push, pop, full, empty;
    logic [CNT_W-1:0] cnt_q;
    logic [QA_W-1:0]  wr_q, rd_q;
    cla_t             mem_q [QUEUE_DEPTH];
    logic [31:0]      issued_q;

    assign cand  = base_q + cla_t'(k_q) * s_q;
    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign pop   = !empty && bus.pf_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            s_q     <= '0;
            deg_q   <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            s_q     <= s_d;
            deg_q   <= deg_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        s_d     = s_q;
        deg_d   = deg_q;
        k_d     = k_q;
        push    = 1'b0;
        if (state_q == S_GEN) begin
            if (cand[CLA_W-1:PG_SH] != base_q[CLA_W-1:PG_SH]) begin
                state_d = S_IDLE;
            end else if (!full) begin
                push = 1'b1;
                if (k_q == deg_q) state_d = S_IDLE;
                else              k_d     = k_q + 1'b1;
            end
        end
        if (trig) begin
            state_d = S_GEN;
            base_d  = cla;
            s_d     = d;
            deg_d   = deg_clamp;
            k_d     = DEG_W'(1);
        end
        if (bus.flush_i) begin
            state_d = S_IDLE;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= cand;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q     <= '0;
            rd_q     <= '0;
            cnt_q    <= '0;
            issued_q <= '0;
        end else begin
            if (pop) issued_q <= issued_q + 32'd1;
            if (bus.flush_i) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) wr_q <= wr_q + 1'b1;
                if (pop)  rd_q <= rd_q + 1'b1;
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + 1'b1;
                    2'b01:   cnt_q <= cnt_q - 1'b1;
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    assign bus.pf_valid_o  = !empty;
    assign bus.pf_addr_o   = empty ? '0 : {mem_q[rd_q], {LOG2_BLOCK{1'b0}}};
    assign bus.pf_issued_o = issued_q;
endmodule

// File: tb/tb_ip_stride_pf_queue.sv
// tb/tb_ip_stride_pf_queue.sv - directed table-driven bench for ip_stride_pf_queue
module tb_ip_stride_pf_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ip_stride_pf_queue_if #(.ADDR_W(64), .DEG_W(4)) bus ();

    ip_stride_pf_queue #(.NUM_TRACKERS(4), .QUEUE_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [63:0] ip;
        logic [63:0] addr;
        logic [3:0]  deg;
        int          n;
        logic [63:0] first;
        logic [63:0] step;
    } row_t;

    int checks = 0;
    int passes = 0;
    row_t rows[$];

    localparam logic [63:0] UP   = 64'h40;
    localparam logic [63:0] DN2  = 64'hFFFF_FFFF_FFFF_FF80;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic row_t mk(input logic [63:0] ip, input logic [63:0] addr, input logic [3:0] deg,
                                input int n, input logic [63:0] first, input logic [63:0] step);
        row_t r;
        r.ip = ip; r.addr = addr; r.deg = deg; r.n = n; r.first = first; r.step = step;
        return r;
    endfunction

    task automatic access(input logic [63:0] ip, input logic [63:0] addr, input logic [3:0] deg);
        bus.req_valid_i = 1'b1;
        bus.ip_i        = ip;
        bus.addr_i      = addr;
        bus.degree_i    = deg;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
    endtask

    task automatic run_row(input int idx, input row_t r);
        logic [63:0] got[$];
        int          cyc[$];
        access(r.ip, r.addr, r.deg);
        for (int c = 0; c < 20; c++) begin
            if (bus.pf_valid_o) begin
                got.push_back(bus.pf_addr_o);
                cyc.push_back(c);
            end
            @(negedge clk);
        end
        chk($sformatf("row%0d count", idx), 64'(got.size()), 64'(r.n));
        for (int i = 0; i < got.size() && i < r.n; i++) begin
            chk($sformatf("row%0d addr%0d", idx, i), got[i], r.first + 64'(i) * r.step);
            if (i == 0) chk($sformatf("row%0d latency", idx), 64'(cyc[0]), 64'd1);
            else        chk($sformatf("row%0d consec%0d", idx, i), 64'(cyc[i]), 64'(cyc[i-1] + 1));
        end
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.addr_i      = '0;
        bus.ip_i        = '0;
        bus.degree_i    = '0;
        bus.flush_i     = 1'b0;
        bus.pf_ready_i  = 1'b0;

        // reset with random inputs
        for (int i = 0; i < 2; i++) begin
            bus.req_valid_i = 1'($urandom);
            bus.addr_i      = {$urandom, $urandom};
            bus.ip_i        = {$urandom, $urandom};
            bus.degree_i    = 4'($urandom);
            bus.pf_ready_i  = 1'($urandom);
            @(negedge clk);
        end
        chk("reset pf_valid", 64'(bus.pf_valid_o), 64'd0);
        chk("reset pf_addr", bus.pf_addr_o, 64'd0);
        chk("reset pf_issued", 64'(bus.pf_issued_o), 64'd0);
        rst = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.pf_ready_i  = 1'b1;
        @(negedge clk);

        // stride +1, degree 3
        rows.push_back(mk(64'h400, 64'h1000, 4'd3, 0, 64'h0, UP));
        rows.push_back(mk(64'h400, 64'h1040, 4'd3, 0, 64'h0, UP));
        rows.push_back(mk(64'h400, 64'h1080, 4'd3, 0, 64'h0, UP));
        rows.push_back(mk(64'h400, 64'h10C0, 4'd3, 3, 64'h1100, UP));
        // page boundary stops generation after one line
        rows.push_back(mk(64'h500, 64'h1EC0, 4'd4, 0, 64'h0, UP));
        rows.push_back(mk(64'h500, 64'h1F00, 4'd4, 0, 64'h0, UP));
        rows.push_back(mk(64'h500, 64'h1F40, 4'd4, 0, 64'h0, UP));
        rows.push_back(mk(64'h500, 64'h1F80, 4'd4, 1, 64'h1FC0, UP));
        // negative stride of two lines
        rows.push_back(mk(64'h600, 64'h3000, 4'd2, 0, 64'h0, DN2));
        rows.push_back(mk(64'h600, 64'h2F80, 4'd2, 0, 64'h0, DN2));
        rows.push_back(mk(64'h600, 64'h2F00, 4'd2, 0, 64'h0, DN2));
        rows.push_back(mk(64'h600, 64'h2E80, 4'd2, 2, 64'h2E00, DN2));
        // LRU eviction of A after B..E, then A retrains from conf 0
        rows.push_back(mk(64'hA00, 64'h8000, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hA00, 64'h8040, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hA00, 64'h8080, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hB00, 64'hB000, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hC00, 64'hC000, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hD00, 64'hD000, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hE00, 64'hE000, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hA00, 64'h80C0, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hA00, 64'h8100, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hA00, 64'h8140, 4'd1, 0, 64'h0, UP));
        rows.push_back(mk(64'hA00, 64'h8180, 4'd1, 1, 64'h81C0, UP));
        // degree clamp to 8, same-line hit ignored, saturated confidence retriggers
        rows.push_back(mk(64'h900, 64'h9000, 4'd15, 0, 64'h0, UP));
        rows.push_back(mk(64'h900, 64'h9040, 4'd15, 0, 64'h0, UP));
        rows.push_back(mk(64'h900, 64'h9080, 4'd15, 0, 64'h0, UP));
        rows.push_back(mk(64'h900, 64'h90C0, 4'd15, 8, 64'h9100, UP));
        rows.push_back(mk(64'h900, 64'h90C8, 4'd15, 0, 64'h0, UP));
        rows.push_back(mk(64'h900, 64'h9100, 4'd15, 8, 64'h9140, UP));
        for (int i = 0; i < rows.size(); i++) run_row(i, rows[i]);
        chk("issued after table", 64'(bus.pf_issued_o), 64'd23);

        // back-pressure: queue fills, generator stalls without loss
        begin
            logic [63:0] got[$];
            bus.pf_ready_i = 1'b0;
            access(64'h700, 64'h4F40, 4'd8);
            access(64'h700, 64'h4F80, 4'd8);
            access(64'h700, 64'h4FC0, 4'd8);
            access(64'h700, 64'h5000, 4'd8);
            repeat (12) @(negedge clk);
            chk("stall pf_valid", 64'(bus.pf_valid_o), 64'd1);
            chk("stall head", bus.pf_addr_o, 64'h5040);
            chk("stall issued", 64'(bus.pf_issued_o), 64'd23);
            bus.pf_ready_i = 1'b1;
            for (int c = 0; c < 40; c++) begin
                if (bus.pf_valid_o) got.push_back(bus.pf_addr_o);
                @(negedge clk);
            end
            chk("drain count", 64'(got.size()), 64'd8);
            for (int i = 0; i < got.size() && i < 8; i++)
                chk($sformatf("drain addr%0d", i), got[i], 64'h5040 + 64'(i) * UP);
            chk("drain issued", 64'(bus.pf_issued_o), 64'd31);
            chk("drain empty", 64'(bus.pf_valid_o), 64'd0);
        end

        // flush during a stall
        bus.pf_ready_i = 1'b0;
        access(64'h700, 64'h5040, 4'd8);
        repeat (8) @(negedge clk);
        chk("preflush pf_valid", 64'(bus.pf_valid_o), 64'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("flush pf_valid", 64'(bus.pf_valid_o), 64'd0);
        chk("flush pf_addr", bus.pf_addr_o, 64'd0);
        repeat (6) @(negedge clk);
        chk("flush fsm idle", 64'(bus.pf_valid_o), 64'd0);
        chk("flush issued", 64'(bus.pf_issued_o), 64'd31);

        // reset mid-generation
        access(64'h700, 64'h5080, 4'd8);
        @(negedge clk);
        chk("pre-reset pf_valid", 64'(bus.pf_valid_o), 64'd1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("midreset pf_valid", 64'(bus.pf_valid_o), 64'd0);
        chk("midreset pf_addr", bus.pf_addr_o, 64'd0);
        chk("midreset issued", 64'(bus.pf_issued_o), 64'd0);
        rst = 1'b0;
        bus.pf_ready_i = 1'b1;
        repeat (6) @(negedge clk);
        chk("postreset pf_valid", 64'(bus.pf_valid_o), 64'd0);
        access(64'h700, 64'h50C0, 4'd8);
        repeat (6) @(negedge clk);
        chk("trackers cleared", 64'(bus.pf_issued_o), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
